// File: rtl/spike_stream_packer.sv
// Framing FIFO between the spike detector result stream and an AXI DMA S2MM channel.
// Beats are tagged with TLAST every FRAME_LEN beats, or early on a flush pulse.
module spike_stream_packer #(
   parameter int unsigned FRAME_LEN  = 16,
   parameter int unsigned FIFO_DEPTH = 32,
   parameter int unsigned DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_axis_data,
   input  logic              s_axis_valid,
   output logic              s_axis_ready,
   input  logic              flush,
   output logic [DATA_W-1:0] m_axis_data,
   output logic              m_axis_valid,
   output logic              m_axis_last,
   input  logic              m_axis_ready,
   output logic [15:0]       frame_count,
   output logic              overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL     = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);
   localparam logic [15:0] BEAT_MAX = 16'(FRAME_LEN - 1);

   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     tail_ptr;
   logic [AW:0]       count;
   logic [15:0]       wr_beat;

   logic              wr_en;
   logic              rd_en;
   logic              wr_last;
   logic              flush_idle;
   logic              tail_resident;
   logic              mark_tail;
   logic              push_filler;
   logic              push;
   logic [DATA_W:0]   push_entry;
   logic [DATA_W:0]   head;

   always_comb begin
      s_axis_ready  = (count != FULL);
      m_axis_valid  = (count != '0);
      head          = mem[rd_ptr];
      m_axis_data   = m_axis_valid ? head[DATA_W-1:0] : '0;
      m_axis_last   = m_axis_valid & head[DATA_W];

      wr_en         = s_axis_valid & s_axis_ready;
      rd_en         = m_axis_valid & m_axis_ready;
      wr_last       = (wr_beat == BEAT_MAX) | flush;
      tail_ptr      = wr_ptr - AW'(1);

      // A bare flush closes the frame on the newest entry if it survives this
      // cycle; otherwise that entry is gone and a zero filler carries TLAST.
      flush_idle    = flush & ~wr_en & (wr_beat != '0);
      tail_resident = (count > ONE) | ((count == ONE) & ~rd_en);
      mark_tail     = flush_idle & tail_resident;
      push_filler   = flush_idle & ~tail_resident;
      push          = wr_en | push_filler;
      push_entry    = wr_en ? {wr_last, s_axis_data} : {1'b1, {DATA_W{1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_entry;
      if (mark_tail)
         mem[tail_ptr][DATA_W] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         wr_beat     <= '0;
         frame_count <= '0;
         overflow    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + AW'(1);

         case ({push, rd_en})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase

         if (wr_en)
            wr_beat <= wr_last ? '0 : wr_beat + 16'd1;
         else if (flush_idle)
            wr_beat <= '0;

         if (rd_en && head[DATA_W])
            frame_count <= frame_count + 16'd1;

         if (s_axis_valid && !s_axis_ready)
            overflow <= 1'b1;
      end
   end

endmodule

// File: doc/spike_stream_packer.md
Name: spike_stream_packer

Overview:
- Sink-side partner to the spike detector core. Consumes the detector's 32-bit AXI-Stream result stream and buffers it in a FIFO.
- Re-emits the data as framed AXI-Stream packets with TLAST, suitable for an AXI DMA S2MM channel.
- Frames close every FRAME_LEN beats, or early on a software flush pulse.
- Sits between the detector master port and the DMA on the PL side.

Parameters:
- FRAME_LEN, 16, beats per full frame (2..65535).
- FIFO_DEPTH, 32, FIFO entries (power of 2, ≥4).
- DATA_W, 32, stream data width.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- s_axis_data  input  DATA_W  detector result beat.
- s_axis_valid  input  1  upstream beat valid.
- s_axis_ready  output  1  packer can accept a beat.
- flush  input  1  one-cycle pulse: close the current partial frame.
- m_axis_data  output  DATA_W  framed output beat.
- m_axis_valid  output  1  output beat valid.
- m_axis_last  output  1  final beat of frame.
- m_axis_ready  input  1  DMA accepts the beat.
- frame_count  output  16  frames completed on the output side (wraps at 16 bits).
- overflow  output  1  sticky flag: upstream presented valid while full.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state:
  - FIFO empty, wr_beat=0, frame_count=0, overflow=0.
  - m_axis_valid=0, m_axis_last=0, m_axis_data=0.
  - s_axis_ready=1 from the first cycle after reset.
  - Reset asserted mid-frame discards all buffered beats and the partial frame; no TLAST is emitted for it.
- FIFO:
  - Entry = {last, data}. Registered count. First-word fall-through.
  - m_axis_valid = (count≠0); m_axis_data/last = head entry.
  - A beat accepted in cycle N is visible on m_axis in cycle N+1.
- Write: when s_axis_valid & s_axis_ready.
  - last = (wr_beat==FRAME_LEN-1) | flush.
  - wr_beat then becomes 0 if last=1, else wr_beat+1.
- Read: when m_axis_valid & m_axis_ready. Pop the head; if head.last=1, frame_count+1.
- s_axis_ready = (count<FIFO_DEPTH), evaluated on the registered count. A simultaneous read does not free space in the same cycle (no pass-through when full).
- Simultaneous read and write when not full: count unchanged, both pointers advance.
- overflow: set when s_axis_valid=1 & s_axis_ready=0. Cleared only by rst.
- Flush with no write in the same cycle:
  - wr_beat=0: no effect.
  - wr_beat≠0 and the newest FIFO entry stays resident this cycle (count>1, or count==1 with no read): set that entry's last bit in place; wr_beat←0.
  - wr_beat≠0 and the newest entry has already left, or leaves this cycle (count==0, or count==1 with a read): push a filler entry {last=1, data=0}. wr_beat←0. Space is guaranteed in this case.
- Flush coincident with a write marks the written beat last. No filler is pushed.
- Pointer wrap: modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- No combinational path from m_axis_ready to s_axis_ready.

Test Plan:
- Full frames: FRAME_LEN=4; send 8 beats 1..8 with m_axis_ready=1 → output 1..8; m_axis_last on beats 4 and 8; frame_count=2; first m_axis_valid one cycle after the first accepted beat.
- Backpressure/full: FIFO_DEPTH=8; m_axis_ready=0; send 10 beats → s_axis_ready drops after beat 8; overflow=1 while valid is held; release ready → beats 1..8 drain in order; beats 9..10 are accepted afterwards.
- Flush with resident tail: FRAME_LEN=16; send 3 beats (0xA,0xB,0xC) with ready=0; pulse flush → on drain 0xC carries last=1; frame_count=1; the next beat begins a new frame.
- Flush after drain: send 2 beats with ready=1 and let them drain; then flush → one filler beat data=0, last=1; frame_count=1. A flush at wr_beat=0 produces no output.
- Flush coincident with write: beat 0x55 on the same cycle as flush at wr_beat=5 → 0x55 has last=1; no filler; wr_beat=0.
- Mid-frame reset: 5 beats buffered, rst for 1 cycle → m_axis_valid=0, frame_count=0, s_axis_ready=1; the subsequent FRAME_LEN beats form one clean frame.
